// File: rtl/spi_cmd_pkg.sv
// Shared types for the SPI command sequencer: opcodes, FSM states and the status byte layout.
package spi_cmd_pkg;

  localparam int unsigned BYTE_W = 8;

  typedef enum logic [1:0] {
    OP_NOP    = 2'b00,
    OP_WRITE  = 2'b01,
    OP_READ   = 2'b10,
    OP_STATUS = 2'b11
  } opcode_e;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    WRITE,
    READ,
    DISCARD
  } state_e;

  typedef struct packed {
    logic       error;
    logic [2:0] rsvd;
    logic [3:0] count;
  } status_t;

  function automatic status_t make_status(input logic err, input logic [3:0] cnt);
    status_t s;
    s.error = err;
    s.rsvd  = 3'b000;
    s.count = cnt;
    return s;
  endfunction

endpackage

// File: rtl/spi_cmd_decode.sv
// Combinational decode of the first byte of a frame into opcode, address and illegal-address flag.
module spi_cmd_decode
  import spi_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W = 3
) (
  input  logic [BYTE_W-1:0] cmd_i,
  output opcode_e           op_c,
  output logic [ADDR_W-1:0] addr_c,
  output logic              illegal_c
);

  // Bits [5:ADDR_W] must be zero for register-access commands.
  localparam logic [5:0] HI_MASK = 6'(6'h3F << ADDR_W);

  assign op_c      = opcode_e'(cmd_i[7:6]);
  assign addr_c    = cmd_i[ADDR_W-1:0];
  assign illegal_c = ((op_c == OP_WRITE) || (op_c == OP_READ)) && (|(cmd_i[5:0] & HI_MASK));

endmodule

// File: rtl/spi_cmd_sequencer.sv
// Frame-level command sequencer behind the SPI byte receiver (burst write/read, status readback).
// Build option: define SPI_CMD_AUTOINC_EN to auto-increment the address after each data byte.
module spi_cmd_sequencer
  import spi_cmd_pkg::*;
#(
  parameter int unsigned ADDR_W = 3
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              CS,
  input  logic [7:0]        Buffer,
  input  logic              Changed,
  output logic              WrEn,
  output logic [ADDR_W-1:0] WrAddr,
  output logic [7:0]        WrData,
  output logic [ADDR_W-1:0] RdAddr,
  input  logic [7:0]        RdData,
  output logic [7:0]        TxData,
  output logic              TxLoad,
  output logic              Busy,
  output logic              Error,
  output logic [7:0]        FrameCount
);

`ifdef SPI_CMD_AUTOINC_EN
  localparam logic AUTOINC = 1'b1;
`else
  localparam logic AUTOINC = 1'b0;
`endif

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic [7:0]        tx_data_q, tx_data_d;
  logic              tx_load_q, tx_load_d;
  logic              busy_q, busy_d;
  logic              error_q, error_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;
  logic              byte_seen_q, byte_seen_d;
  logic              rd_pend_q, rd_pend_d;

  opcode_e           dec_op;
  logic [ADDR_W-1:0] dec_addr;
  logic              dec_illegal;
  logic [ADDR_W-1:0] addr_next;

  spi_cmd_decode #(.ADDR_W(ADDR_W)) u_decode (
    .cmd_i     (Buffer),
    .op_c      (dec_op),
    .addr_c    (dec_addr),
    .illegal_c (dec_illegal)
  );

  assign addr_next = AUTOINC ? (addr_q + ADDR_W'(1)) : addr_q;

  // State and datapath registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      rd_addr_q   <= '0;
      wr_en_q     <= 1'b0;
      wr_addr_q   <= '0;
      wr_data_q   <= '0;
      tx_data_q   <= '0;
      tx_load_q   <= 1'b0;
      busy_q      <= 1'b0;
      error_q     <= 1'b0;
      frame_cnt_q <= '0;
      byte_seen_q <= 1'b0;
      rd_pend_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      rd_addr_q   <= rd_addr_d;
      wr_en_q     <= wr_en_d;
      wr_addr_q   <= wr_addr_d;
      wr_data_q   <= wr_data_d;
      tx_data_q   <= tx_data_d;
      tx_load_q   <= tx_load_d;
      busy_q      <= busy_d;
      error_q     <= error_d;
      frame_cnt_q <= frame_cnt_d;
      byte_seen_q <= byte_seen_d;
      rd_pend_q   <= rd_pend_d;
    end
  end

  // Next-state and output logic
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    rd_addr_d   = rd_addr_q;
    wr_en_d     = 1'b0;
    wr_addr_d   = wr_addr_q;
    wr_data_d   = wr_data_q;
    tx_data_d   = tx_data_q;
    tx_load_d   = 1'b0;
    error_d     = error_q;
    frame_cnt_d = frame_cnt_q;
    byte_seen_d = byte_seen_q;
    rd_pend_d   = 1'b0;

    // Read data is captured the cycle after RdAddr has been registered.
    if (rd_pend_q) begin
      tx_data_d = RdData;
      tx_load_d = 1'b1;
    end

    if (state_q == IDLE) begin
      byte_seen_d = 1'b0;
      if (!CS) state_d = CMD;
    end else if (CS) begin
      state_d = IDLE;
      if (byte_seen_q) frame_cnt_d = frame_cnt_q + 8'd1;
    end else if (Changed) begin
      byte_seen_d = 1'b1;
      case (state_q)
        CMD: begin
          if (dec_illegal) begin
            error_d = 1'b1;
            state_d = DISCARD;
          end else begin
            case (dec_op)
              OP_WRITE: begin
                addr_d  = dec_addr;
                state_d = WRITE;
              end
              OP_READ: begin
                addr_d    = dec_addr;
                rd_addr_d = dec_addr;
                rd_pend_d = 1'b1;
                state_d   = READ;
              end
              OP_STATUS: begin
                tx_data_d = make_status(error_q, frame_cnt_q[3:0]);
                tx_load_d = 1'b1;
                error_d   = 1'b0;
                state_d   = DISCARD;
              end
              default: state_d = DISCARD;
            endcase
          end
        end
        WRITE: begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = Buffer;
          addr_d    = addr_next;
        end
        READ: begin
          addr_d    = addr_next;
          rd_addr_d = addr_next;
          rd_pend_d = 1'b1;
        end
        default: ;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  assign WrEn       = wr_en_q;
  assign WrAddr     = wr_addr_q;
  assign WrData     = wr_data_q;
  assign RdAddr     = rd_addr_q;
  assign TxData     = tx_data_q;
  assign TxLoad     = tx_load_q;
  assign Busy       = busy_q;
  assign Error      = error_q;
  assign FrameCount = frame_cnt_q;

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer with a write/TX scoreboard checked at negedge.
module tb_spi_cmd_sequencer;

  localparam int unsigned ADDR_W = 3;

`ifdef SPI_CMD_AUTOINC_EN
  localparam bit AI = 1'b1;
`else
  localparam bit AI = 1'b0;
`endif

  logic              CLK = 1'b0;
  logic              RST;
  logic              CS;
  logic [7:0]        Buffer;
  logic              Changed;
  logic              WrEn;
  logic [ADDR_W-1:0] WrAddr;
  logic [7:0]        WrData;
  logic [ADDR_W-1:0] RdAddr;
  logic [7:0]        RdData;
  logic [7:0]        TxData;
  logic              TxLoad;
  logic              Busy;
  logic              Error;
  logic [7:0]        FrameCount;

  typedef struct {
    int unsigned cyc;
    logic [7:0]  addr;
    logic [7:0]  data;
  } exp_t;

  exp_t        wr_q[$];
  exp_t        tx_q[$];
  int unsigned cyc = 0;
  int          cmp_cnt = 0;
  int          err_cnt = 0;

  spi_cmd_sequencer #(.ADDR_W(ADDR_W)) dut (
    .CLK(CLK), .RST(RST), .CS(CS), .Buffer(Buffer), .Changed(Changed),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData), .RdAddr(RdAddr), .RdData(RdData),
    .TxData(TxData), .TxLoad(TxLoad), .Busy(Busy), .Error(Error), .FrameCount(FrameCount)
  );

  // Register file model: each entry reads back as addr*16
  assign RdData = 8'({RdAddr, 4'h0});

  always #5 CLK = ~CLK;
  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    cmp_cnt++;
    assert (got === exp) else begin
      err_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Scoreboard: pop expected write/TX events as the DUT produces them
  always @(negedge CLK) begin
    exp_t e;
    if (WrEn === 1'b1) begin
      if (wr_q.size() == 0) chk("wr_unexpected", 32'(WrEn), 32'd0);
      else begin
        e = wr_q.pop_front();
        chk("wr_addr", 32'(WrAddr), 32'(e.addr));
        chk("wr_data", 32'(WrData), 32'(e.data));
        chk("wr_cycle", cyc, e.cyc);
      end
    end
    if (TxLoad === 1'b1) begin
      if (tx_q.size() == 0) chk("tx_unexpected", 32'(TxLoad), 32'd0);
      else begin
        e = tx_q.pop_front();
        chk("tx_data", 32'(TxData), 32'(e.data));
        chk("tx_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // kind: 0 none, 1 write expected at N+1, 2 read TX at N+2, 3 status TX at N+1
  task automatic send_byte(input logic [7:0] b, input int kind,
                           input logic [7:0] ea, input logic [7:0] ed);
    exp_t e;
    @(posedge CLK); #1;
    e.addr = ea;
    e.data = ed;
    if (kind == 1) begin e.cyc = cyc + 1; wr_q.push_back(e); end
    if (kind == 2) begin e.cyc = cyc + 2; tx_q.push_back(e); end
    if (kind == 3) begin e.cyc = cyc + 1; tx_q.push_back(e); end
    Buffer  = b;
    Changed = 1'b1;
    @(posedge CLK); #1;
    Changed = 1'b0;
    repeat (7) @(posedge CLK);
    #1;
  endtask

  task automatic cs_low();
    @(posedge CLK); #1;
    CS = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
  endtask

  task automatic cs_high(input string tag);
    @(posedge CLK); #1;
    CS = 1'b1;
    @(negedge CLK);
    chk({tag, "_busy_before"}, 32'(Busy), 32'd1);
    @(negedge CLK);
    chk({tag, "_busy_after"}, 32'(Busy), 32'd0);
    @(posedge CLK); #1;
  endtask

  initial begin
    RST = 1'b1; CS = 1'b0; Buffer = 8'h41; Changed = 1'b0;
    // Reset held while a frame is active and Changed toggles
    for (int i = 0; i < 6; i++) begin
      @(posedge CLK); #1;
      Changed = ~Changed;
    end
    Changed = 1'b0;
    @(negedge CLK);
    chk("rst_wren", 32'(WrEn), 32'd0);
    chk("rst_wr", 32'({WrAddr, WrData}), 32'd0);
    chk("rst_rdaddr", 32'(RdAddr), 32'd0);
    chk("rst_tx", 32'({TxData, TxLoad}), 32'd0);
    chk("rst_busy", 32'(Busy), 32'd0);
    chk("rst_err_cnt", 32'({Error, FrameCount}), 32'd0);
    @(posedge CLK); #1;
    CS = 1'b1; RST = 1'b0;
    repeat (2) @(posedge CLK);
    #1;

    // Burst write starting at 1
    cs_low();
    chk("a_busy", 32'(Busy), 32'd1);
    send_byte(8'h41, 0, 8'h0, 8'h0);
    send_byte(8'h7A, 1, 8'h1, 8'h7A);
    send_byte(8'h80, 1, AI ? 8'h2 : 8'h1, 8'h80);
    cs_high("a");
    chk("a_framecount", 32'(FrameCount), 32'd1);

    // Burst read from 7, wrapping to 0 with auto-increment
    cs_low();
    send_byte(8'h87, 2, 8'h0, 8'h70);
    send_byte(8'h00, 2, 8'h0, AI ? 8'h00 : 8'h70);
    send_byte(8'h00, 2, 8'h0, AI ? 8'h10 : 8'h70);
    cs_high("b");
    chk("b_rdaddr", 32'(RdAddr), AI ? 32'd1 : 32'd7);
    chk("b_framecount", 32'(FrameCount), 32'd2);

    // Illegal address bit: error, no write
    cs_low();
    send_byte(8'h4C, 0, 8'h0, 8'h0);
    send_byte(8'h0C, 0, 8'h0, 8'h0);
    chk("c_error", 32'(Error), 32'd1);
    cs_high("c");
    chk("c_framecount", 32'(FrameCount), 32'd3);

    // Status readback reports and clears the error
    cs_low();
    send_byte(8'hC0, 3, 8'h0, 8'h83);
    chk("d_error_cleared", 32'(Error), 32'd0);
    cs_high("d");
    chk("d_framecount", 32'(FrameCount), 32'd4);

    // Second write burst at 3
    cs_low();
    send_byte(8'h43, 0, 8'h0, 8'h0);
    send_byte(8'h0C, 1, 8'h3, 8'h0C);
    send_byte(8'h40, 1, AI ? 8'h4 : 8'h3, 8'h40);
    cs_high("e");
    chk("e_framecount", 32'(FrameCount), 32'd5);

    // Byte coinciding with CS rising is dropped
    cs_low();
    send_byte(8'h45, 0, 8'h0, 8'h0);
    send_byte(8'h11, 1, 8'h5, 8'h11);
    @(posedge CLK); #1;
    Buffer = 8'h22; Changed = 1'b1; CS = 1'b1;
    @(posedge CLK); #1;
    Changed = 1'b0;
    @(negedge CLK);
    chk("f_idle_after_drop", 32'(Busy), 32'd0);
    repeat (3) @(posedge CLK);
    #1;
    chk("f_framecount", 32'(FrameCount), 32'd6);

    // Empty frame is not counted
    cs_low();
    cs_high("g");
    chk("g_framecount", 32'(FrameCount), 32'd6);

    // Set error, then reset mid-write with a byte arriving
    cs_low();
    send_byte(8'h48, 0, 8'h0, 8'h0);
    cs_high("h");
    chk("h_error", 32'(Error), 32'd1);
    cs_low();
    send_byte(8'h41, 0, 8'h0, 8'h0);
    @(posedge CLK); #1;
    RST = 1'b1; Buffer = 8'h55; Changed = 1'b1;
    @(posedge CLK); #1;
    RST = 1'b0; Changed = 1'b0; CS = 1'b1;
    @(negedge CLK);
    chk("h_rst_busy", 32'(Busy), 32'd0);
    chk("h_rst_err_cnt", 32'({Error, FrameCount}), 32'd0);
    repeat (3) @(posedge CLK);
    #1;

    // Frame counter wraps 255 -> 0
    for (int i = 0; i < 256; i++) begin
      cs_low();
      send_byte(8'h00, 0, 8'h0, 8'h0);
      @(posedge CLK); #1;
      CS = 1'b1;
      repeat (2) @(posedge CLK);
      #1;
      if (i == 254) chk("wrap_255", 32'(FrameCount), 32'd255);
    end
    chk("wrap_0", 32'(FrameCount), 32'd0);

    repeat (4) @(posedge CLK);
    #1;
    chk("wr_queue_drained", 32'(wr_q.size()), 32'd0);
    chk("tx_queue_drained", 32'(tx_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/spi_cmd_sequencer.md
# spi_cmd_sequencer

Command-level controller behind the SPI byte receiver: consumes the byte stream (`Buffer`/`Changed`) framed by chip select and sequences a small external register file. It decodes the first byte of each frame as a command, then performs burst writes, burst reads or a status readback. It also drives the transmit byte plus load strobe for the outgoing shift path. It runs in the same `CLK` domain as the byte receiver.

## Interface
- `ADDR_W`, 3: register address width; the register file holds 2^ADDR_W 8-bit entries; legal range 1..6.
- `CLK`  in  1  clock, shared with the byte receiver.
- `RST`  in  1  reset, synchronous, active-high.
- `CS`  in  1  chip select, active-low; one frame is one contiguous low interval.
- `Buffer`  in  8  received byte, valid while `Changed`=1.
- `Changed`  in  1  one-cycle strobe: a new byte is in `Buffer`.
- `WrEn`  out  1  register write strobe, one cycle per byte.
- `WrAddr`  out  ADDR_W  write address.
- `WrData`  out  8  write data.
- `RdAddr`  out  ADDR_W  registered read address.
- `RdData`  in  8  register file output, combinational from `RdAddr`.
- `TxData`  out  8  next byte to shift out.
- `TxLoad`  out  1  one-cycle strobe: `TxData` updated.
- `Busy`  out  1  high when state is not IDLE.
- `Error`  out  1  sticky protocol-error flag.
- `FrameCount`  out  8  completed non-empty frames, mod 256.

## Operation
- Reset: state IDLE, internal address 0; all outputs 0.
- IDLE: `CS`=0 sampled, next state CMD. `Changed` is ignored while `CS`=1.
- CMD: the first `Changed` decodes `Buffer[7:6]`:
  - 00 NOP: next state DISCARD.
  - 01 WRITE: address <= `Buffer[ADDR_W-1:0]`; next state WRITE.
  - 10 READ: address <= `Buffer[ADDR_W-1:0]`, `RdAddr` <= same; next state READ. `TxData` <= `RdData` with `TxLoad` one cycle later.
  - 11 STATUS: `TxData` <= `{Error, 3'b000, FrameCount[3:0]}` with `TxLoad`; `Error` cleared in the same cycle; next state DISCARD.
- Any nonzero bit in `Buffer[5:ADDR_W]` on WRITE/READ: `Error` <= 1, next state DISCARD, no register access.
- WRITE: each `Changed` drives one `WrEn` pulse with `WrAddr`=address and `WrData`=`Buffer`, then address advances (see Configuration).
- READ: each `Changed` advances address and `RdAddr`; the next cycle captures `TxData` <= `RdData` and pulses `TxLoad`.
- DISCARD: bytes ignored until the end of the frame.
- Frame end: `CS`=1 sampled in any non-IDLE state gives IDLE next cycle. `FrameCount` increments if at least one byte arrived in the frame; it wraps 255 to 0.
- `Changed` and `CS`=1 in the same cycle: the byte is dropped and the frame ends.
- `RST` mid-frame: returns to IDLE immediately. `Error` and `FrameCount` are cleared; no pending `WrEn`/`TxLoad` is issued.

## Timing
- Command byte to state change: 1 cycle (registered).
- Write latency: `Changed` in cycle N gives `WrEn`/`WrAddr`/`WrData` valid in cycle N+1.
- Read latency: `Changed` in cycle N updates `RdAddr` at N+1; `TxData`/`TxLoad` at N+2.
- STATUS latency: `TxLoad` at N+1.
- `Changed` pulses are at least 8 cycles apart (one byte); no back-pressure exists.
- `Busy` falls the cycle after `CS` rises.

## Configuration
- `SPI_CMD_AUTOINC_EN` defined: the address increments after each data byte in WRITE and READ, wrapping 2^ADDR_W-1 to 0.
- Not defined: the address stays fixed for the whole frame. Every write hits the same register; every read returns the same register.

## Structure
- Shared package `spi_cmd_pkg`: opcode constants (NOP/WRITE/READ/STATUS = 2'b00/01/10/11), state enum (IDLE, CMD, WRITE, READ, DISCARD), status-byte layout.
- One sub-module `spi_cmd_decode`: combinational decode of the command byte into opcode, address and illegal-address flag.
- The FSM, address counter, frame counter and TX path stay in the top module.

## Test plan
- Reset with `CS`=0 and `Changed` toggling -> all outputs 0, `Busy`=0.
- Frame 0x41, 0x7A, 0x80 (ADDR_W=3, macro defined) -> `WrEn` twice: addr 1 data 0x7A, then addr 2 data 0x80. After `CS` rises, `FrameCount`=1.
- Frame 0x87, two dummy bytes, register file returning addr*16 -> `TxData` 0x70, 0x00, 0x10 (address wraps 7 to 0), each with one `TxLoad` pulse at N+2.
- Frame 0x4C (illegal address bit 3) then 0x0C -> `Error`=1, no `WrEn`. The next frame 0xC0 -> `TxData`=0x80|count, `Error` cleared.
- Macro undefined, frame 0x43, 0x0C, 0x40 -> two writes, both to addr 3.
- `CS` rises in the same cycle as `Changed` mid-WRITE -> that byte is not written, and the state is IDLE the following cycle.
